// File: rtl/dest_tracker.sv
// rtl/dest_tracker.sv - ID/EX/MEM/WB destination tracker with load-use stall detection
module dest_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic        validID,
    input  logic [4:0]  rs1ID,
    input  logic [4:0]  rs2ID,
    input  logic [4:0]  rdID,
    input  logic        useRs1ID,
    input  logic        useRs2ID,
    input  logic        regWriteID,
    input  logic        memReadID,
    input  logic        flushID,
    input  logic        memStall,
    output logic [4:0]  rs1EX,
    output logic [4:0]  rs2EX,
    output logic [4:0]  rdEX,
    output logic        memReadEX,
    output logic [4:0]  rdMEM,
    output logic        regWriteMEM,
    output logic [4:0]  rdWB,
    output logic        regWriteWB,
    output logic        stallID,
    output logic [31:0] retired
);

    logic        ex_valid;
    logic        ex_reg_write;
    logic        mem_valid;
    logic        wb_valid;
    logic [31:0] retired_cnt;
    logic        id_take;
    logic        rs1_hit;
    logic        rs2_hit;

    assign rs1_hit = useRs1ID & (rs1ID == rdEX);
    assign rs2_hit = useRs2ID & (rs2ID == rdEX);

    // Load in EX whose result is needed by the ID instruction: hold ID one cycle.
    // Deliberately independent of memStall so the hazard stays visible while frozen.
    assign stallID = validID & ~flushID & memReadEX & (rdEX != 5'd0) & (rs1_hit | rs2_hit);

    // The ID instruction enters EX only when it is real, not flushed and not stalled.
    assign id_take = validID & ~flushID & ~stallID;

    assign retired = retired_cnt;

    // ID/EX stage: capture the ID instruction or a zeroed bubble on each advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            rs1EX        <= 5'd0;
            rs2EX        <= 5'd0;
            rdEX         <= 5'd0;
            ex_reg_write <= 1'b0;
            memReadEX    <= 1'b0;
        end else if (!memStall) begin
            if (id_take) begin
                ex_valid     <= 1'b1;
                rs1EX        <= rs1ID;
                rs2EX        <= rs2ID;
                rdEX         <= rdID;
                ex_reg_write <= regWriteID & (rdID != 5'd0);
                memReadEX    <= memReadID;
            end else begin
                ex_valid     <= 1'b0;
                rs1EX        <= 5'd0;
                rs2EX        <= 5'd0;
                rdEX         <= 5'd0;
                ex_reg_write <= 1'b0;
                memReadEX    <= 1'b0;
            end
        end
    end

    // EX/MEM stage: follows ID/EX on every unfrozen edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            rdMEM       <= 5'd0;
            regWriteMEM <= 1'b0;
        end else if (!memStall) begin
            mem_valid   <= ex_valid;
            rdMEM       <= rdEX;
            regWriteMEM <= ex_reg_write;
        end
    end

    // MEM/WB stage: follows EX/MEM on every unfrozen edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            rdWB       <= 5'd0;
            regWriteWB <= 1'b0;
        end else if (!memStall) begin
            wb_valid   <= mem_valid;
            rdWB       <= rdMEM;
            regWriteWB <= regWriteMEM;
        end
    end

    // Retirement counter: an instruction retires as it leaves WB; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= 32'd0;
        end else if (!memStall && wb_valid) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

endmodule
